// File: rtl/rom_loader_if.sv
// ROM loader bus: incoming byte stream plus the ROM byte-lane write port.
interface rom_loader_if;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        w_en;
    logic [31:0] w_addr;
    logic [31:0] w_data;
    logic [3:0]  w_sel;

    // Loader side: consumes bytes, drives ROM writes.
    modport master (
        input  rx_valid,
        input  rx_data,
        output w_en,
        output w_addr,
        output w_data,
        output w_sel
    );

    // Environment side: supplies bytes, observes ROM writes.
    modport slave (
        output rx_valid,
        output rx_data,
        input  w_en,
        input  w_addr,
        input  w_data,
        input  w_sel
    );
endinterface

// File: rtl/rom_loader.sv
// Boot loader: parses a length-prefixed, checksummed byte frame and writes
// the payload as little-endian words into the instruction ROM.
module rom_loader #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned MAX_BYTES      = 65536,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_i,
    rom_loader_if.master  bus,
    output logic          cpu_hold_o,
    output logic          busy_o,
    output logic          done_o,
    output logic          err_o
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 8;
    localparam int unsigned LANES = DW / BW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_e;

    state_e             state_q, state_d;
    logic [AW-1:0]      len_q, len_d;
    logic [AW-1:0]      cnt_q, cnt_d;
    logic [BW-1:0]      sum_q, sum_d;
    logic [DW-1:0]      wbuf_q, wbuf_d;
    logic [LANES-1:0]   sel_q, sel_d;
    logic [AW-1:0]      tmo_q, tmo_d;
    logic               w_en_q, w_en_d;
    logic [AW-1:0]      w_addr_q, w_addr_d;
    logic [DW-1:0]      w_data_q, w_data_d;
    logic [LANES-1:0]   w_sel_q, w_sel_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               err_q, err_d;

    logic [DW-1:0]      wbuf_nxt;
    logic [LANES-1:0]   sel_nxt;
    logic [AW-1:0]      len_nxt;
    logic               last_byte;
    logic               loading;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            len_q    <= '0;
            cnt_q    <= '0;
            sum_q    <= '0;
            wbuf_q   <= '0;
            sel_q    <= '0;
            tmo_q    <= '0;
            w_en_q   <= 1'b0;
            w_addr_q <= '0;
            w_data_q <= '0;
            w_sel_q  <= '0;
            hold_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            wbuf_q   <= wbuf_d;
            sel_q    <= sel_d;
            tmo_q    <= tmo_d;
            w_en_q   <= w_en_d;
            w_addr_q <= w_addr_d;
            w_data_q <= w_data_d;
            w_sel_q  <= w_sel_d;
            hold_q   <= hold_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next-state, frame parsing, word assembly and timeout.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        wbuf_d   = wbuf_q;
        sel_d    = sel_q;
        tmo_d    = tmo_q;
        w_en_d   = 1'b0;
        w_addr_d = w_addr_q;
        w_data_d = w_data_q;
        w_sel_d  = w_sel_q;

        wbuf_nxt = wbuf_q;
        wbuf_nxt[{cnt_q[1:0], 3'b000} +: BW] = bus.rx_data;
        sel_nxt   = sel_q | (LANES'(1) << cnt_q[1:0]);
        len_nxt   = {bus.rx_data, len_q[AW-1:BW]};
        last_byte = (cnt_q == (len_q - AW'(1)));
        loading   = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d = S_LEN;
                    len_d   = '0;
                    cnt_d   = '0;
                    sum_d   = '0;
                    wbuf_d  = '0;
                    sel_d   = '0;
                    tmo_d   = '0;
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    len_d = len_nxt;
                    cnt_d = cnt_q + AW'(1);
                    if (cnt_q == AW'(3)) begin
                        cnt_d = '0;
                        if (len_nxt > AW'(MAX_BYTES)) begin
                            state_d = S_ERR;
                        end else if (len_nxt == '0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (bus.rx_valid) begin
                    sum_d  = sum_q + bus.rx_data;
                    cnt_d  = cnt_q + AW'(1);
                    wbuf_d = wbuf_nxt;
                    sel_d  = sel_nxt;
                    if ((cnt_q[1:0] == 2'd3) || last_byte) begin
                        w_en_d   = 1'b1;
                        w_addr_d = BASE_ADDR + {cnt_q[AW-1:2], 2'b00};
                        w_data_d = wbuf_nxt;
                        w_sel_d  = sel_nxt;
                        wbuf_d   = '0;
                        sel_d    = '0;
                    end
                    if (last_byte) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    state_d = (bus.rx_data == sum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Idle-gap watchdog while a frame is being received.
        if (loading) begin
            if (bus.rx_valid) begin
                tmo_d = '0;
            end else begin
                tmo_d = tmo_q + AW'(1);
                if ((TIMEOUT_CYCLES != 0) && (tmo_d == AW'(TIMEOUT_CYCLES))) begin
                    state_d = S_ERR;
                end
            end
        end
    end

    // Status flags follow the state being entered so they stay registered.
    always_comb begin
        hold_d = (state_d == S_LEN) || (state_d == S_DATA) ||
                 (state_d == S_CSUM) || (state_d == S_ERR);
        busy_d = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
        done_d = (state_d == S_DONE);
        err_d  = (state_d == S_ERR);
    end

    assign bus.w_en   = w_en_q;
    assign bus.w_addr = w_addr_q;
    assign bus.w_data = w_data_q;
    assign bus.w_sel  = w_sel_q;
    assign cpu_hold_o = hold_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

endmodule
